oversample_filter: RTL and testbench

Per-channel oversampling averager that sits directly upstream of the PID filter. It consumes the time-multiplexed ADC sample stream (dv/chan/data) and accumulates 2^osf_log samples per channel. It then emits one averaged sample per channel per window, using the same dv/chan/data format that the PID filter accepts. Each channel's oversample ratio is set through the shared wr_en/wr_addr/wr_chan/wr_data config bus.

---
 rtl/oversample_filter_pkg.sv | 22 ++
 rtl/oversample_filter.sv | 171 +++++++++++++++++
 tb/tb_oversample_filter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/oversample_filter_pkg.sv
// Shared constants for the oversampling averager: config address map entry,
// default geometry and the accumulator width derivation.
package oversample_filter_pkg;

    localparam int W_CHAN_DEF      = 5;
    localparam int N_CHAN_DEF      = 8;
    localparam int W_DIN_DEF       = 18;
    localparam int W_OSF_LOG_DEF   = 4;
    localparam int OSF_LOG_MAX_DEF = 10;
    localparam int W_WR_ADDR_DEF   = 16;
    localparam int W_WR_CHAN_DEF   = 16;
    localparam int W_WR_DATA_DEF   = 48;

    // Sits alongside the pid_* config addresses on the shared write bus.
    localparam logic [15:0] OSF_LOG_ADDR = 16'h0048;

    // Room for 2^log_max full-scale samples, so the sum can never overflow.
    function automatic int acc_width(input int w_din, input int log_max);
        return w_din + log_max;
    endfunction

endpackage

// File: rtl/oversample_filter.sv
// Per-channel 2^osf_log oversampling averager: two-stage fetch/accumulate pipe
// over per-channel accumulator, count and ratio memories.
module oversample_filter
    import oversample_filter_pkg::*;
#(
    parameter int W_CHAN      = W_CHAN_DEF,
    parameter int N_CHAN      = N_CHAN_DEF,
    parameter int W_DIN       = W_DIN_DEF,
    parameter int W_DOUT      = W_DIN_DEF,
    parameter int W_OSF_LOG   = W_OSF_LOG_DEF,
    parameter int OSF_LOG_MAX = OSF_LOG_MAX_DEF,
    parameter int W_WR_ADDR   = W_WR_ADDR_DEF,
    parameter int W_WR_CHAN   = W_WR_CHAN_DEF,
    parameter int W_WR_DATA   = W_WR_DATA_DEF
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        dv_in,
    input  logic [W_CHAN-1:0]           chan_in,
    input  logic signed [W_DIN-1:0]     data_in,
    input  logic                        wr_en,
    input  logic [W_WR_ADDR-1:0]        wr_addr,
    input  logic [W_WR_CHAN-1:0]        wr_chan,
    input  logic [W_WR_DATA-1:0]        wr_data,
    output logic                        dv_out,
    output logic [W_CHAN-1:0]           chan_out,
    output logic signed [W_DOUT-1:0]    data_out
);

    localparam int W_ACC = acc_width(W_DIN, OSF_LOG_MAX);
    localparam int W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam logic [W_CHAN-1:0]    N_CHAN_TAG = W_CHAN'(N_CHAN);
    localparam logic [W_WR_CHAN-1:0] N_CHAN_WR  = W_WR_CHAN'(N_CHAN);
    localparam logic [W_OSF_LOG-1:0] LOG_MAX    = W_OSF_LOG'(OSF_LOG_MAX);
    localparam logic [W_WR_ADDR-1:0] CFG_ADDR   = W_WR_ADDR'(OSF_LOG_ADDR);

    logic signed [W_ACC-1:0]     acc_mem_q [N_CHAN];
    logic signed [W_ACC-1:0]     acc_mem_d [N_CHAN];
    logic [OSF_LOG_MAX-1:0]      cnt_mem_q [N_CHAN];
    logic [OSF_LOG_MAX-1:0]      cnt_mem_d [N_CHAN];
    logic [W_OSF_LOG-1:0]        log_mem_q [N_CHAN];
    logic [W_OSF_LOG-1:0]        log_mem_d [N_CHAN];

    logic                        s1_dv_q,   s1_dv_d;
    logic [W_CHAN-1:0]           s1_chan_q, s1_chan_d;
    logic signed [W_DIN-1:0]     s1_data_q, s1_data_d;
    logic signed [W_ACC-1:0]     s1_acc_q,  s1_acc_d;
    logic [OSF_LOG_MAX-1:0]      s1_cnt_q,  s1_cnt_d;
    logic [W_OSF_LOG-1:0]        s1_log_q,  s1_log_d;

    logic                        dv_out_q,   dv_out_d;
    logic [W_CHAN-1:0]           chan_out_q, chan_out_d;
    logic signed [W_DOUT-1:0]    data_out_q, data_out_d;

    logic                        cfg_wr;
    logic [W_IDX-1:0]            cfg_idx;
    logic [W_OSF_LOG-1:0]        cfg_log;

    logic [W_IDX-1:0]            s1_idx;
    logic [W_IDX-1:0]            in_idx;
    logic                        s2_kill;
    logic                        s2_last;
    logic [OSF_LOG_MAX:0]        s2_one_shift;
    logic signed [W_ACC-1:0]     s2_acc_next;
    logic signed [W_ACC-1:0]     s2_avg;
    logic                        wb_en;
    logic signed [W_ACC-1:0]     wb_acc;
    logic [OSF_LOG_MAX-1:0]      wb_cnt;
    logic                        unused_bits;

    always_comb begin
        cfg_idx = wr_chan[W_IDX-1:0];
        cfg_log = (wr_data[W_OSF_LOG-1:0] > LOG_MAX) ? LOG_MAX : wr_data[W_OSF_LOG-1:0];
        cfg_wr  = wr_en && (wr_addr == CFG_ADDR) && (wr_chan < N_CHAN_WR);
    end

    // Stage 2: accumulate and decide; a same-channel config write discards the sample.
    always_comb begin
        s1_idx       = s1_chan_q[W_IDX-1:0];
        s2_kill      = cfg_wr && (cfg_idx == s1_idx);
        wb_en        = s1_dv_q && !s2_kill;
        s2_acc_next  = s1_acc_q + {{OSF_LOG_MAX{s1_data_q[W_DIN-1]}}, s1_data_q};
        s2_one_shift = {{OSF_LOG_MAX{1'b0}}, 1'b1} << s1_log_q;
        s2_last      = (s1_cnt_q == (s2_one_shift[OSF_LOG_MAX-1:0] - 1'b1));
        s2_avg       = s2_acc_next >>> s1_log_q;
        wb_acc       = s2_last ? '0 : s2_acc_next;
        wb_cnt       = s2_last ? '0 : s1_cnt_q + 1'b1;
        dv_out_d     = wb_en && s2_last;
        chan_out_d   = s1_chan_q;
        data_out_d   = dv_out_d ? s2_avg[W_DOUT-1:0] : data_out_q;
    end

    // Stage 1: fetch with forwarding from the writeback and config write landing this edge.
    always_comb begin
        in_idx    = chan_in[W_IDX-1:0];
        s1_dv_d   = dv_in && (chan_in < N_CHAN_TAG) && !(cfg_wr && (cfg_idx == in_idx));
        s1_chan_d = chan_in;
        s1_data_d = data_in;
        s1_acc_d  = acc_mem_q[in_idx];
        s1_cnt_d  = cnt_mem_q[in_idx];
        s1_log_d  = log_mem_q[in_idx];
        if (wb_en && (s1_idx == in_idx)) begin
            s1_acc_d = wb_acc;
            s1_cnt_d = wb_cnt;
        end
        if (cfg_wr && (cfg_idx == in_idx)) begin
            s1_acc_d = '0;
            s1_cnt_d = '0;
            s1_log_d = cfg_log;
        end
    end

    always_comb begin
        for (int c = 0; c < N_CHAN; c++) begin
            acc_mem_d[c] = acc_mem_q[c];
            cnt_mem_d[c] = cnt_mem_q[c];
            log_mem_d[c] = log_mem_q[c];
            if (wb_en && (s1_idx == W_IDX'(c))) begin
                acc_mem_d[c] = wb_acc;
                cnt_mem_d[c] = wb_cnt;
            end
            if (cfg_wr && (cfg_idx == W_IDX'(c))) begin
                acc_mem_d[c] = '0;
                cnt_mem_d[c] = '0;
                log_mem_d[c] = cfg_log;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int c = 0; c < N_CHAN; c++) begin
                acc_mem_q[c] <= '0;
                cnt_mem_q[c] <= '0;
                log_mem_q[c] <= '0;
            end
            s1_dv_q    <= 1'b0;
            s1_chan_q  <= '0;
            s1_data_q  <= '0;
            s1_acc_q   <= '0;
            s1_cnt_q   <= '0;
            s1_log_q   <= '0;
            dv_out_q   <= 1'b0;
            chan_out_q <= '0;
            data_out_q <= '0;
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                acc_mem_q[c] <= acc_mem_d[c];
                cnt_mem_q[c] <= cnt_mem_d[c];
                log_mem_q[c] <= log_mem_d[c];
            end
            s1_dv_q    <= s1_dv_d;
            s1_chan_q  <= s1_chan_d;
            s1_data_q  <= s1_data_d;
            s1_acc_q   <= s1_acc_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_log_q   <= s1_log_d;
            dv_out_q   <= dv_out_d;
            chan_out_q <= chan_out_d;
            data_out_q <= data_out_d;
        end
    end

    assign dv_out   = dv_out_q;
    assign chan_out = chan_out_q;
    assign data_out = data_out_q;

    assign unused_bits = ^{wr_data[W_WR_DATA-1:W_OSF_LOG], s2_avg[W_ACC-1:W_DOUT],
                           s2_one_shift[OSF_LOG_MAX]};

endmodule

// File: tb/tb_oversample_filter.sv
// Directed bench for oversample_filter: pass-through, windowed averages,
// interleaving, full-scale, config collision, invalid channel and reset.
module tb_oversample_filter;
    import oversample_filter_pkg::*;

    localparam int W_CHAN    = 5;
    localparam int W_DIN     = 18;
    localparam int W_WR_ADDR = 16;
    localparam int W_WR_CHAN = 16;
    localparam int W_WR_DATA = 48;

    logic                      clk_in = 1'b0;
    logic                      rst_in;
    logic                      dv_in;
    logic [W_CHAN-1:0]         chan_in;
    logic signed [W_DIN-1:0]   data_in;
    logic                      wr_en;
    logic [W_WR_ADDR-1:0]      wr_addr;
    logic [W_WR_CHAN-1:0]      wr_chan;
    logic [W_WR_DATA-1:0]      wr_data;
    logic                      dv_out;
    logic [W_CHAN-1:0]         chan_out;
    logic signed [W_DIN-1:0]   data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    oversample_filter dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .dv_in    (dv_in),
        .chan_in  (chan_in),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_chan  (wr_chan),
        .wr_data  (wr_data),
        .dv_out   (dv_out),
        .chan_out (chan_out),
        .data_out (data_out)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input bit v, input int ch, input int d);
        dv_in   = v;
        chan_in = W_CHAN'(ch);
        data_in = W_DIN'(d);
    endtask

    task automatic set_cfg(input int ch, input int lg);
        wr_en   = 1'b1;
        wr_addr = W_WR_ADDR'(OSF_LOG_ADDR);
        wr_chan = W_WR_CHAN'(ch);
        wr_data = W_WR_DATA'(lg);
    endtask

    task automatic cfg_write(input int ch, input int lg);
        set_cfg(ch, lg);
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        drive(0, 0, 0);
        wr_en = 1'b0; wr_addr = '0; wr_chan = '0; wr_data = '0;
        step();
        step();
        checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL reset_dv dv_out=%b expected 0", dv_out); end
        checks++; if (chan_out !== '0) begin errors++; $display("FAIL reset_chan chan_out=%0d expected 0", chan_out); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data data_out=%0d expected 0", data_out); end
        rst_in = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_passthrough();
        int samp[3] = '{5, -7, 131071};
        logic signed [W_DIN-1:0] e;
        cfg_write(0, 0);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1, 0, samp[i]); else drive(0, 0, 0);
            step();
            if (i >= 1 && i <= 3) begin
                e = W_DIN'(samp[i-1]);
                checks++; if (dv_out !== 1'b1) begin errors++; $display("FAIL pass_dv[%0d] dv_out=%b expected 1", i, dv_out); end
                checks++; if (data_out !== e) begin errors++; $display("FAIL pass_data[%0d] data_out=%0d expected %0d", i, data_out, e); end
                checks++; if (chan_out !== 5'd0) begin errors++; $display("FAIL pass_chan[%0d] chan_out=%0d expected 0", i, chan_out); end
            end
            if (i == 4) begin
                checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL pass_idle dv_out=%b expected 0", dv_out); end
                checks++; if (data_out !== 18'sd131071) begin errors++; $display("FAIL pass_hold data_out=%0d expected 131071", data_out); end
            end
        end
        $display("test_passthrough done");
    endtask

    task automatic test_window();
        int samp[4] = '{10, 11, 12, 13};
        cfg_write(3, 2);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1, 3, samp[i]); else drive(0, 3, 0);
            step();
            if (i >= 1) begin
                checks++; if (dv_out !== (i == 4)) begin errors++; $display("FAIL window_dv[%0d] dv_out=%b expected %b", i, dv_out, (i == 4)); end
            end
            if (i == 4) begin
                checks++; if (data_out !== 18'sd11) begin errors++; $display("FAIL window_data data_out=%0d expected 11", data_out); end
                checks++; if (chan_out !== 5'd3) begin errors++; $display("FAIL window_chan chan_out=%0d expected 3", chan_out); end
            end
        end
        $display("test_window done");
    endtask

    task automatic test_interleave();
        int chs[4]  = '{1, 2, 1, 2};
        int samp[4] = '{-3, 8, -4, 9};
        cfg_write(1, 1);
        cfg_write(2, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1, chs[i], samp[i]); else drive(0, 0, 0);
            step();
            if (i >= 1) begin
                checks++; if (dv_out !== (i == 3 || i == 4)) begin errors++; $display("FAIL inter_dv[%0d] dv_out=%b expected %b", i, dv_out, (i == 3 || i == 4)); end
            end
            if (i == 3) begin
                checks++; if (data_out !== -18'sd4) begin errors++; $display("FAIL inter_ch1_data data_out=%0d expected -4", data_out); end
                checks++; if (chan_out !== 5'd1) begin errors++; $display("FAIL inter_ch1_chan chan_out=%0d expected 1", chan_out); end
            end
            if (i == 4) begin
                checks++; if (data_out !== 18'sd8) begin errors++; $display("FAIL inter_ch2_data data_out=%0d expected 8", data_out); end
                checks++; if (chan_out !== 5'd2) begin errors++; $display("FAIL inter_ch2_chan chan_out=%0d expected 2", chan_out); end
            end
        end
        $display("test_interleave done");
    endtask

    task automatic test_collision();
        int samp[7] = '{100, 200, 300, 1, 2, 3, 6};
        cfg_write(4, 2);
        for (int i = 0; i < 9; i++) begin
            if (i < 7) drive(1, 4, samp[i]); else drive(0, 4, 0);
            if (i == 2) set_cfg(4, 2);
            step();
            wr_en = 1'b0;
            if (i >= 1) begin
                checks++; if (dv_out !== (i == 7)) begin errors++; $display("FAIL collide_dv[%0d] dv_out=%b expected %b", i, dv_out, (i == 7)); end
            end
            if (i == 7) begin
                checks++; if (data_out !== 18'sd3) begin errors++; $display("FAIL collide_data data_out=%0d expected 3", data_out); end
                checks++; if (chan_out !== 5'd4) begin errors++; $display("FAIL collide_chan chan_out=%0d expected 4", chan_out); end
            end
        end
        $display("test_collision done");
    endtask

    task automatic test_invalid_chan();
        drive(1, 8, 77);
        step();
        drive(1, 6, -20);
        step();
        checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL invalid_drop dv_out=%b expected 0", dv_out); end
        drive(0, 0, 0);
        step();
        checks++; if (dv_out !== 1'b1) begin errors++; $display("FAIL invalid_next_dv dv_out=%b expected 1", dv_out); end
        checks++; if (data_out !== -18'sd20) begin errors++; $display("FAIL invalid_next_data data_out=%0d expected -20", data_out); end
        checks++; if (chan_out !== 5'd6) begin errors++; $display("FAIL invalid_next_chan chan_out=%0d expected 6", chan_out); end
        $display("test_invalid_chan done");
    endtask

    task automatic test_full_scale();
        int pulses;
        int at;
        logic signed [W_DIN-1:0] got;
        for (int run = 0; run < 2; run++) begin
            // first run writes 15, which must saturate to the maximum ratio of 10
            cfg_write(0, (run == 0) ? 15 : 10);
            pulses = 0; at = -1; got = '0;
            for (int i = 0; i < 1026; i++) begin
                if (i < 1023) drive(1, 0, -131072);
                else if (i == 1023) drive(1, 0, (run == 0) ? -131072 : -1);
                else drive(0, 0, 0);
                step();
                if (dv_out === 1'b1) begin pulses++; at = i; got = data_out; end
            end
            checks++; if (pulses != 1) begin errors++; $display("FAIL full_pulses[%0d] count=%0d expected 1", run, pulses); end
            checks++; if (at != 1024) begin errors++; $display("FAIL full_timing[%0d] step=%0d expected 1024", run, at); end
            if (run == 0) begin
                checks++; if (got !== -18'sd131072) begin errors++; $display("FAIL full_data[0] data_out=%0d expected -131072", got); end
            end else begin
                checks++; if (got !== -18'sd130945) begin errors++; $display("FAIL full_data[1] data_out=%0d expected -130945", got); end
            end
            $display("test_full_scale run %0d done", run);
        end
    endtask

    task automatic test_reset_mid();
        cfg_write(5, 2);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 7);
            step();
            if (i >= 1) begin
                checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL rmid_pre_dv[%0d] dv_out=%b expected 0", i, dv_out); end
            end
        end
        drive(0, 0, 0);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL rmid_dv dv_out=%b expected 0", dv_out); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL rmid_data data_out=%0d expected 0", data_out); end
        step();
        checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL rmid_after dv_out=%b expected 0", dv_out); end
        drive(1, 5, 42);
        step();
        drive(0, 0, 0);
        step();
        checks++; if (dv_out !== 1'b1) begin errors++; $display("FAIL rmid_pass_dv dv_out=%b expected 1", dv_out); end
        checks++; if (data_out !== 18'sd42) begin errors++; $display("FAIL rmid_pass_data data_out=%0d expected 42", data_out); end
        checks++; if (chan_out !== 5'd5) begin errors++; $display("FAIL rmid_pass_chan chan_out=%0d expected 5", chan_out); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_window();
        test_interleave();
        test_collision();
        test_invalid_chan();
        test_full_scale();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
